// File: rtl/axi_lite_ar_issue.sv
// AXI-Lite read-address master stage: request FIFO, AR issue FSM, outstanding
// read tracking against R-stage completions, and a stall timeout pulse.
module axi_lite_ar_issue #(
  parameter int ADDR_W          = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 1,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_prot,
  output logic              req_ready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rd_done,
  output logic [3:0]        outstanding,
  output logic              busy,
  output logic              timeout,
  output logic              proto_err
);

  // state | meaning
  // IDLE  | waiting for a queued request and a free outstanding slot
  // ADDR  | arvalid held with stable araddr/arprot until arready
  // GAP   | one bubble cycle after the handshake
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [2:0]        fifo_prot_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ready_en_q;
  logic              fifo_empty, fifo_full, push, pop;

  logic [1:0]        state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;

  logic [3:0]        outstanding_q, outstanding_d;
  logic              proto_err_q, proto_err_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              ar_hs, stall, tmo_clr, tmo_tc;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // ready_en_q keeps req_ready low for the first cycle after reset releases
  assign req_ready = ready_en_q && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && !fifo_empty &&
                     (outstanding_q < 4'(MAX_OUTSTANDING));
  assign ar_hs     = arvalid_q && arready;

  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arprot_d  = arprot_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          araddr_d  = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
          arprot_d  = fifo_prot_q[rd_ptr_q[IDX_W-1:0]];
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: begin
        arvalid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    proto_err_d   = proto_err_q;
    if (ar_hs && !rd_done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!ar_hs && rd_done && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    if (rd_done && (outstanding_q == 4'd0)) begin
      proto_err_d = 1'b1;
    end
  end

  // Timer restarts after each pulse, so an unbroken stall pulses every TIMEOUT_CYCLES
  assign stall     = (arvalid_q && !arready) || ((outstanding_q != 4'd0) && !rd_done);
  assign tmo_clr   = ar_hs || rd_done || !stall;
  assign tmo_tc    = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = (tmo_clr || tmo_tc) ? '0 : tmo_cnt_q + CNT_W'(1);
  assign timeout   = !tmo_clr && tmo_tc;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= req_addr;
      fifo_prot_q[wr_ptr_q[IDX_W-1:0]] <= req_prot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ready_en_q    <= 1'b0;
      state_q       <= S_IDLE;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arprot_q      <= '0;
      outstanding_q <= '0;
      proto_err_q   <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ready_en_q    <= 1'b1;
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arprot_q      <= arprot_d;
      outstanding_q <= outstanding_d;
      proto_err_q   <= proto_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign arvalid     = arvalid_q;
  assign araddr      = araddr_q;
  assign arprot      = arprot_q;
  assign outstanding = outstanding_q;
  assign proto_err   = proto_err_q;
  assign busy        = !fifo_empty || arvalid_q || (outstanding_q != 4'd0);

endmodule

// File: tb/tb_axi_lite_ar_issue.sv
// Bench for axi_lite_ar_issue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based transaction model.
module tb_axi_lite_ar_issue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 1;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_prot;
  logic        req_ready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic        rd_done;
  logic [3:0]  outstanding;
  logic        busy;
  logic        timeout;
  logic        proto_err;

  axi_lite_ar_issue #(
    .ADDR_W(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_prot(req_prot), .req_ready(req_ready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rd_done(rd_done), .outstanding(outstanding), .busy(busy),
    .timeout(timeout), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending requests as a queue, one AR slot, cooldown after handshake
  typedef struct packed { logic [31:0] a; logic [2:0] p; } req_t;
  req_t        mq[$];
  bit          m_ren, m_av, m_cool, m_perr;
  int          m_outs, m_tcnt;
  logic [31:0] m_aa;
  logic [2:0]  m_ap;

  function automatic bit model_timeout(input bit ar, input bit rd);
    bit stl;
    stl = (m_av && !ar) || (m_outs != 0 && !rd);
    return stl && !(m_av && ar) && !rd && (m_tcnt == TMO - 1);
  endfunction

  function automatic void model_edge(input bit rv, input logic [31:0] a, input logic [2:0] p,
                                     input bit ar, input bit rd, input bit rs);
    bit push_ok, hs, stl;
    int outs_pre;
    req_t r;
    if (rs) begin
      mq.delete();
      m_ren = 0; m_av = 0; m_cool = 0; m_perr = 0;
      m_outs = 0; m_tcnt = 0; m_aa = '0; m_ap = '0;
      return;
    end
    push_ok  = rv && m_ren && (mq.size() < DEPTH);
    hs       = m_av && ar;
    outs_pre = m_outs;
    stl      = (m_av && !ar) || (m_outs != 0 && !rd);
    if (hs || rd || !stl || m_tcnt == TMO - 1) m_tcnt = 0;
    else m_tcnt++;
    if (m_cool) m_cool = 0;
    else if (m_av) begin
      if (ar) begin m_av = 0; m_cool = 1; end
    end else if (mq.size() > 0 && outs_pre < MAXO) begin
      r = mq.pop_front();
      m_aa = r.a; m_ap = r.p; m_av = 1;
    end
    if (rd && m_outs == 0) m_perr = 1;
    if (hs && !rd) m_outs++;
    else if (!hs && rd && m_outs > 0) m_outs--;
    if (push_ok) begin
      r.a = a; r.p = p;
      mq.push_back(r);
    end
    m_ren = 1;
  endfunction

  // One clock cycle: drive just after posedge, check at negedge, advance model at posedge
  task automatic step(input bit rv, input logic [31:0] a, input logic [2:0] p,
                      input bit ar, input bit rd, input bit rs);
    req_valid = rv; req_addr = a; req_prot = p;
    arready = ar; rd_done = rd; reset = rs;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(m_ren && (mq.size() < DEPTH)));
    chk("arvalid", 64'(arvalid), 64'(m_av));
    if (m_av) begin
      chk("araddr", 64'(araddr), 64'(m_aa));
      chk("arprot", 64'(arprot), 64'(m_ap));
    end
    chk("outstanding", 64'(outstanding), 64'(m_outs));
    chk("busy", 64'(busy), 64'((mq.size() > 0) || m_av || (m_outs != 0)));
    chk("timeout", 64'(timeout), 64'(model_timeout(ar, rd)));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    @(posedge clk);
    model_edge(rv, a, p, ar, rd, rs);
    #1;
  endtask

  task automatic idle(input int n, input bit ar);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 3'd0, ar, 1'b0, 1'b0);
  endtask

  int pv_t[6]  = '{80, 30, 95, 50, 20, 70};
  int pa_t[6]  = '{60, 90, 30, 10, 100, 50};
  int prd_t[6] = '{30, 60, 5, 40, 2, 20};

  initial begin
    req_valid = 1'b0; req_addr = '0; req_prot = '0;
    arready = 1'b0; rd_done = 1'b0; reset = 1'b1;
    model_edge(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle(1, 1'b0);

    // single read with arvalid two cycles after acceptance
    step(1'b1, 32'h1000, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // backpressure for 10+ cycles, then handshake and completion
    step(1'b1, 32'h2468, 3'd5, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);

    // one read held open, FIFO overfilled, rd_done withheld long enough to time out twice
    step(1'b1, 32'h0F00, 3'd1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 3'(i), 1'b1, 1'b0, 1'b0);
    idle(36, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 3'd0, 1'b1, m_outs > 0, 1'b0);

    // rd_done with nothing outstanding, then reset while arvalid is high
    step(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 32'hABCD, 3'd7, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit rv, ar, rd, rs;
      ph = (i / 500) % 6;
      rv = ($urandom_range(99) < pv_t[ph]);
      ar = ($urandom_range(99) < pa_t[ph]);
      if (m_outs > 0) rd = ($urandom_range(99) < prd_t[ph]);
      else rd = !m_av && ($urandom_range(99) < 2);
      rs = ($urandom_range(999) < 3);
      step(rv, $urandom, 3'($urandom_range(7)), ar, rd, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
